// File: rtl/instruction_sequencer.sv
// CHIP-8 instruction sequencer: fetches big-endian opcodes, resolves control flow locally
// (jumps, call/return, skips, key-wait) and hands everything else to the execute stage.
module instruction_sequencer #(
    parameter int STACK_DEPTH = 16,
    parameter int ADDR_W      = 12,
    localparam int IDX_W      = $clog2(STACK_DEPTH),
    localparam int SP_W       = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic [3:0]        reg_x,
    output logic [3:0]        reg_y,
    input  logic [7:0]        vx_data,
    input  logic [7:0]        vy_data,
    input  logic [7:0]        v0_data,
    input  logic              key_pressed,
    output logic              branching,
    output logic [ADDR_W-1:0] branch,
    output logic              offsetting,
    output logic [15:0]       offset,
    output logic              advance,
    output logic [15:0]       opcode,
    output logic              opcode_valid,
    input  logic              exec_ready,
    output logic              key_wait,
    output logic              stack_fault,
    output logic [2:0]        dbg_state_o,
    output logic [SP_W-1:0]   dbg_sp_o
);

    localparam logic [2:0] S_FETCH_HI = 3'd0;
    localparam logic [2:0] S_FETCH_LO = 3'd1;
    localparam logic [2:0] S_LATCH    = 3'd2;
    localparam logic [2:0] S_EXEC     = 3'd3;
    localparam logic [2:0] S_DISPATCH = 3'd4;
    localparam logic [2:0] S_WAIT_KEY = 3'd5;

    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [2:0]        state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d, sp_m1;
    logic [15:0]       opcode_q, opcode_d;
    logic [7:0]        hi_q, hi_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic              push_en;
    logic [ADDR_W-1:0] push_val;
    logic              is_skip, take_skip;
    logic [ADDR_W-1:0] nnn;
    logic [7:0]        nn;
    logic              unused_pc_hi;

    assign unused_pc_hi = ^pc[15:ADDR_W];
    assign nnn          = ADDR_W'(opcode_q[11:0]);
    assign nn           = opcode_q[7:0];
    assign sp_m1        = sp_q - SP_W'(1);

    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        opcode_d     = opcode_q;
        hi_d         = hi_q;
        fault_d      = fault_q;
        push_en      = 1'b0;
        push_val     = '0;
        is_skip      = 1'b0;
        take_skip    = 1'b0;
        mem_addr     = '0;
        mem_rd_en    = 1'b0;
        branching    = 1'b0;
        branch       = '0;
        offsetting   = 1'b0;
        offset       = '0;
        advance      = 1'b0;
        opcode_valid = 1'b0;
        // Gating on rst keeps every output quiet while reset is held, whatever the state.
        if (!rst) begin
            case (state_q)
                S_FETCH_HI: begin
                    mem_addr  = pc[ADDR_W-1:0];
                    mem_rd_en = 1'b1;
                    state_d   = S_FETCH_LO;
                end
                S_FETCH_LO: begin
                    mem_addr  = pc[ADDR_W-1:0] + ADDR_W'(1);
                    mem_rd_en = 1'b1;
                    hi_d      = mem_rdata;
                    state_d   = S_LATCH;
                end
                S_LATCH: begin
                    opcode_d = {hi_q, mem_rdata};
                    state_d  = S_EXEC;
                end
                S_EXEC: begin
                    state_d = S_FETCH_HI;
                    case (opcode_q[15:12])
                        4'h1: begin
                            branching = 1'b1;
                            branch    = nnn;
                        end
                        4'hB: begin
                            branching = 1'b1;
                            branch    = nnn + ADDR_W'(v0_data);
                        end
                        4'h2: begin
                            if (sp_q == SP_FULL) begin
                                fault_d = 1'b1;
                                advance = 1'b1;
                            end else begin
                                push_en   = 1'b1;
                                push_val  = pc[ADDR_W-1:0] + ADDR_W'(2);
                                sp_d      = sp_q + SP_W'(1);
                                branching = 1'b1;
                                branch    = nnn;
                            end
                        end
                        4'h0: begin
                            if (opcode_q == 16'h00EE) begin
                                if (sp_q == '0) begin
                                    fault_d = 1'b1;
                                    advance = 1'b1;
                                end else begin
                                    sp_d      = sp_m1;
                                    branching = 1'b1;
                                    branch    = stack_q[sp_m1[IDX_W-1:0]];
                                end
                            end else begin
                                state_d = S_DISPATCH;
                            end
                        end
                        4'h3: begin
                            is_skip   = 1'b1;
                            take_skip = (vx_data == nn);
                        end
                        4'h4: begin
                            is_skip   = 1'b1;
                            take_skip = (vx_data != nn);
                        end
                        4'h5, 4'h9: begin
                            if (opcode_q[3:0] == 4'h0) begin
                                is_skip   = 1'b1;
                                take_skip = (opcode_q[15:12] == 4'h5) ? (vx_data == vy_data)
                                                                      : (vx_data != vy_data);
                            end else begin
                                state_d = S_DISPATCH;
                            end
                        end
                        4'hF: state_d = (nn == 8'h0A) ? S_WAIT_KEY : S_DISPATCH;
                        default: state_d = S_DISPATCH;
                    endcase
                    if (is_skip) begin
                        if (take_skip) begin
                            offsetting = 1'b1;
                            offset     = 16'd2;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                S_WAIT_KEY: begin
                    if (key_pressed) state_d = S_DISPATCH;
                end
                S_DISPATCH: begin
                    opcode_valid = 1'b1;
                    if (exec_ready) begin
                        advance = 1'b1;
                        state_d = S_FETCH_HI;
                    end
                end
                default: state_d = S_FETCH_HI;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH_HI;
            sp_q     <= '0;
            opcode_q <= '0;
            hi_q     <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            opcode_q <= opcode_d;
            hi_q     <= hi_d;
            fault_q  <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) stack_q[sp_q[IDX_W-1:0]] <= push_val;
    end

    assign reg_x       = opcode_q[11:8];
    assign reg_y       = opcode_q[7:4];
    assign opcode      = opcode_q;
    assign key_wait    = !rst && (state_q == S_WAIT_KEY);
    assign stack_fault = fault_q;
    assign dbg_state_o = state_q;
    assign dbg_sp_o    = sp_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with a byte memory, register file and PC unit model.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic [11:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata;
    logic [3:0]  reg_x, reg_y;
    logic [7:0]  vx_data, vy_data, v0_data;
    logic        key_pressed;
    logic        branching;
    logic [11:0] branch;
    logic        offsetting;
    logic [15:0] offset;
    logic        advance;
    logic [15:0] opcode;
    logic        opcode_valid;
    logic        exec_ready;
    logic        key_wait;
    logic        stack_fault;
    logic [2:0]  dbg_state;
    logic [4:0]  dbg_sp;

    logic [7:0]  mem [4096];
    logic [7:0]  v_regs [16];
    logic        pc_set_en;
    logic [15:0] pc_set;
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    instruction_sequencer dut (
        .clk(clk), .rst(rst), .pc(pc),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .reg_x(reg_x), .reg_y(reg_y),
        .vx_data(vx_data), .vy_data(vy_data), .v0_data(v0_data),
        .key_pressed(key_pressed),
        .branching(branching), .branch(branch),
        .offsetting(offsetting), .offset(offset),
        .advance(advance),
        .opcode(opcode), .opcode_valid(opcode_valid), .exec_ready(exec_ready),
        .key_wait(key_wait), .stack_fault(stack_fault),
        .dbg_state_o(dbg_state), .dbg_sp_o(dbg_sp)
    );

    assign vx_data = v_regs[reg_x];
    assign vy_data = v_regs[reg_y];
    assign v0_data = v_regs[0];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // PC unit model reacting to the sequencer's control pulses
    always @(posedge clk) begin
        if (pc_set_en)       pc <= pc_set;
        else if (branching)  pc <= {4'h0, branch};
        else if (offsetting) pc <= pc + 16'd2 + offset;
        else if (advance)    pc <= pc + 16'd2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_cycles();
        repeat (3) step();
    endtask

    task automatic hold_reset(input logic [15:0] start);
        rst       = 1'b1;
        pc_set    = start;
        pc_set_en = 1'b1;
        step();
        step();
    endtask

    task automatic release_reset();
        rst       = 1'b0;
        pc_set_en = 1'b0;
        #1;
    endtask

    task automatic put_op(input int addr, input logic [15:0] op);
        mem[addr]     = op[15:8];
        mem[addr + 1] = op[7:0];
    endtask

    initial begin
        rst         = 1'b1;
        pc_set_en   = 1'b1;
        pc_set      = '0;
        key_pressed = 1'b0;
        exec_ready  = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) v_regs[i] = 8'h00;

        put_op(12'h020, 16'h1234);
        put_op(12'h300, 16'h00EE);
        put_op(12'h040, 16'h3A05);
        put_op(12'h044, 16'h3A05);
        put_op(12'h060, 16'hF30A);
        put_op(12'h080, 16'hBFFF);
        put_op(12'h001, 16'h6A12);
        put_op(12'h0A0, 16'h5AB0);
        put_op(12'h0A4, 16'h5AB1);
        put_op(12'h200, 16'h00EE);
        mem[12'hFFF] = 8'h00;
        mem[12'h000] = 8'hE0;
        for (int k = 0; k < 17; k++) put_op(12'h100 + 2 * k, 16'h2000 | 16'(12'h102 + 2 * k));

        // Reset state
        hold_reset(16'h0020);
        check("rst_state", dbg_state, 3'd0);
        check("rst_sp", dbg_sp, 5'd0);
        check("rst_opcode", opcode, 16'h0000);
        check("rst_fault", stack_fault, 1'b0);
        check("rst_outs", {mem_rd_en, mem_addr, branching, offsetting, advance, opcode_valid, key_wait},
              '0);

        // 1NNN jump, fetch timing
        release_reset();
        check("jmp_rd_hi", {mem_rd_en, mem_addr}, {1'b1, 12'h020});
        step();
        check("jmp_rd_lo", {mem_rd_en, mem_addr}, {1'b1, 12'h021});
        step();
        check("jmp_latch_rd", mem_rd_en, 1'b0);
        step();
        check("jmp_opcode", opcode, 16'h1234);
        check("jmp_pulse", {branching, branch, offsetting, advance}, {1'b1, 12'h234, 1'b0, 1'b0});
        step();
        check("jmp_next_fetch", mem_addr, 12'h234);

        // Call then return: patch 0x020 to 2300
        put_op(12'h020, 16'h2300);
        hold_reset(16'h0020);
        release_reset();
        fetch_cycles();
        check("call_pulse", {branching, branch}, {1'b1, 12'h300});
        step();
        check("call_sp", dbg_sp, 5'd1);
        fetch_cycles();
        check("ret_pulse", {branching, branch, advance}, {1'b1, 12'h022, 1'b0});
        step();
        check("ret_sp", dbg_sp, 5'd0);
        check("ret_fault", stack_fault, 1'b0);
        check("ret_next_fetch", mem_addr, 12'h022);

        // 3XNN taken and not taken
        v_regs[4'hA] = 8'h05;
        hold_reset(16'h0040);
        release_reset();
        fetch_cycles();
        check("skip_eq_take", {offsetting, offset, branching, advance}, {1'b1, 16'h0002, 1'b0, 1'b0});
        step();
        check("skip_eq_pc", mem_addr, 12'h044);
        v_regs[4'hA] = 8'h06;
        fetch_cycles();
        check("skip_eq_miss", {offsetting, offset, branching, advance}, {1'b0, 16'h0000, 1'b0, 1'b1});

        // 5XY0 taken, 5XY1 dispatched
        v_regs[4'hB] = 8'h06;
        hold_reset(16'h00A0);
        release_reset();
        fetch_cycles();
        check("skip_xy_take", {offsetting, offset, advance}, {1'b1, 16'h0002, 1'b0});
        step();
        fetch_cycles();
        check("skip_xy1_exec", {offsetting, advance, branching}, 3'b000);
        step();
        check("skip_xy1_disp", {opcode_valid, opcode}, {1'b1, 16'h5AB1});
        exec_ready = 1'b1;
        #1;
        check("skip_xy1_hs", advance, 1'b1);
        step();
        exec_ready = 1'b0;

        // Stack overflow on 17th nested call
        hold_reset(16'h0100);
        release_reset();
        for (int k = 0; k < 16; k++) begin
            fetch_cycles();
            check("nest_call", {branching, branch}, {1'b1, 12'(12'h102 + 2 * k)});
            step();
        end
        check("nest_sp16", dbg_sp, 5'd16);
        fetch_cycles();
        check("ovf_pulse", {advance, branching}, 2'b10);
        step();
        check("ovf_fault", {stack_fault, dbg_sp}, {1'b1, 5'd16});

        // Underflow after reset
        hold_reset(16'h0200);
        check("udf_rst_fault", stack_fault, 1'b0);
        release_reset();
        fetch_cycles();
        check("udf_pulse", {advance, branching}, 2'b10);
        step();
        check("udf_fault", {stack_fault, dbg_sp}, {1'b1, 5'd0});

        // FX0A key wait
        hold_reset(16'h0060);
        release_reset();
        fetch_cycles();
        check("kw_exec_quiet", {branching, offsetting, advance}, 3'b000);
        step();
        for (int c = 0; c < 10; c++) begin
            check("kw_wait", {key_wait, branching, offsetting, advance, opcode_valid}, 5'b10000);
            step();
        end
        key_pressed = 1'b1;
        step();
        key_pressed = 1'b0;
        #1;
        check("kw_disp", {opcode_valid, opcode, advance, key_wait}, {1'b1, 16'hF30A, 1'b0, 1'b0});
        exec_ready = 1'b1;
        #1;
        check("kw_hs_adv", advance, 1'b1);
        step();
        exec_ready = 1'b0;
        #1;
        check("kw_after", {dbg_state, opcode_valid, mem_addr}, {3'd0, 1'b0, 12'h062});

        // BNNN wrap then 6XNN with stalled handshake
        v_regs[0] = 8'h02;
        hold_reset(16'h0080);
        release_reset();
        fetch_cycles();
        check("bnnn_pulse", {branching, branch}, {1'b1, 12'h001});
        step();
        fetch_cycles();
        check("ld_exec", {opcode_valid, advance}, 2'b00);
        step();
        for (int c = 0; c < 3; c++) begin
            check("ld_stall", {opcode_valid, opcode, advance}, {1'b1, 16'h6A12, 1'b0});
            step();
        end
        exec_ready = 1'b1;
        #1;
        check("ld_hs", {opcode_valid, advance}, 2'b11);
        step();
        exec_ready = 1'b0;
        #1;
        check("ld_next_fetch", mem_addr, 12'h003);

        // Second-byte address wraps at the top of memory
        hold_reset(16'h0FFF);
        release_reset();
        check("wrap_hi", mem_addr, 12'hFFF);
        step();
        check("wrap_lo", mem_addr, 12'h000);
        step();
        step();
        check("wrap_exec", {opcode, branching, advance}, {16'h00E0, 1'b0, 1'b0});
        step();
        check("wrap_disp", opcode_valid, 1'b1);
        exec_ready = 1'b1;
        #1;
        step();
        exec_ready = 1'b0;

        // Reset during FETCH_LO
        hold_reset(16'h0020);
        put_op(12'h020, 16'h1234);
        release_reset();
        step();
        check("abort_in_lo", dbg_state, 3'd1);
        rst = 1'b1;
        step();
        check("abort_outs", {mem_rd_en, mem_addr, branching, offsetting, advance, opcode_valid, key_wait},
              '0);
        check("abort_state", {dbg_state, opcode}, {3'd0, 16'h0000});
        rst = 1'b0;
        #1;
        check("abort_restart", {mem_rd_en, mem_addr}, {1'b1, 12'h020});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Consumes the current program counter and fetches each 16-bit CHIP-8 opcode from byte-wide program memory, big-endian. Control-flow opcodes are resolved locally: jumps, call/return using a 16-entry return stack, conditional skips and key-wait. The block drives the branch/offset/advance controls back into the PC unit. All other opcodes go to the execute stage over a valid/ready handshake.

Parameters:
STACK_DEPTH, 16, return-stack entries (power of 2)
ADDR_W, 12, memory address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pc  in  16  current program counter; only [11:0] used
mem_addr  out  12  program memory byte address
mem_rd_en  out  1  memory read strobe; data returns next cycle
mem_rdata  in  8  memory read data
reg_x  out  4  register-file read index X = opcode[11:8]
reg_y  out  4  register-file read index Y = opcode[7:4]
vx_data  in  8  V[reg_x], combinational read
vy_data  in  8  V[reg_y], combinational read
v0_data  in  8  V0
key_pressed  in  1  any key down
branching  out  1  pulse: PC <= branch
branch  out  12  branch target
offsetting  out  1  pulse: PC <= PC + 2 + offset
offset  out  16  signed offset
advance  out  1  pulse: PC <= PC + 2
opcode  out  16  latched opcode
opcode_valid  out  1  opcode offered to execute stage
exec_ready  in  1  execute accepts opcode
key_wait  out  1  high while blocked in FX0A
stack_fault  out  1  sticky overflow/underflow flag

Behaviour:
- Reset values: state FETCH_HI; sp=0; opcode=0; stack_fault=0. All other outputs are 0.
- Reset mid-instruction aborts the instruction. Fetch restarts from pc on the first cycle after reset is released.
- FSM states: FETCH_HI, FETCH_LO, LATCH, EXEC, DISPATCH, WAIT_KEY.
- FETCH_HI: mem_addr=pc[11:0]; mem_rd_en=1; next state FETCH_LO.
- FETCH_LO: mem_addr=pc[11:0]+1, wrapping 0xFFF->0x000; mem_rd_en=1; hi byte <= mem_rdata; next state LATCH.
- LATCH: opcode <= {hi, mem_rdata}; next state EXEC.
- reg_x and reg_y are driven combinationally from the opcode register.
- EXEC is a single cycle that issues exactly one control pulse or changes state. Control pulses last one cycle.
- Minimum latency is 4 cycles per control-flow instruction. The PC updates at the end of EXEC; the next state is FETCH_HI.
- 1NNN: branching; branch=NNN.
- BNNN: branching; branch=(NNN+v0_data) mod 4096.
- 2NNN with sp<STACK_DEPTH: stack[sp] <= pc[11:0]+2 (12-bit wrap); sp++; branching to NNN.
- 2NNN with sp==STACK_DEPTH: stack_fault <= 1; advance; sp unchanged.
- 00EE with sp>0: sp--; branching; branch=stack[sp-1].
- 00EE with sp==0: stack_fault <= 1; advance.
- 3XNN: offsetting with offset=+2 if vx_data==NN, else advance.
- 4XNN: same as 3XNN with the condition vx_data!=NN.
- 5XY0: same with vx_data==vy_data.
- 9XY0: same with vx_data!=vy_data.
- Skips use the low nibble only for 5XY0/9XY0; nonzero low-nibble forms are dispatched to execute.
- FX0A: next state WAIT_KEY with no pulse. key_wait=1 while in WAIT_KEY.
- WAIT_KEY: on key_pressed go to DISPATCH. No control pulses are issued while waiting.
- All other opcodes: next state DISPATCH.
- DISPATCH: opcode_valid=1 and opcode held stable until exec_ready.
- In the cycle where opcode_valid and exec_ready are both high: advance pulses; next state FETCH_HI.
- branching, offsetting and advance are mutually exclusive. At most one fires per instruction.
- branch and offset are 0 when their strobe is low.
- stack_fault clears only on reset.

Test Plan:
- mem[0x020..0x021]=12 34, pc=0x020 -> mem reads at 0x020 then 0x021; 4th cycle branching=1 with branch=0x234; no advance.
- Call and return: 23 00 at 0x020, 00 EE at 0x300 -> push 0x022 and branch=0x300 with sp=1; then branch=0x022 with sp=0 and stack_fault=0.
- 3A05 with vx_data=0x05 -> offsetting=1, offset=0x0002. Same opcode with vx_data=0x06 -> advance=1 only.
- 16 nested 2NNN, then a 17th -> 17th gives stack_fault=1, advance, sp=16. After reset, 00EE at sp=0 -> stack_fault=1, advance.
- F30A -> key_wait=1 and no pulses for 10 cycles. key_pressed -> opcode_valid with opcode=0xF30A. exec_ready -> advance in the same cycle.
- BFFF with v0_data=0x02 -> branch=0x001. 6A12 with exec_ready low 3 cycles -> opcode_valid held with opcode stable; advance fires only on the handshake cycle.
- Assert rst during FETCH_LO -> all outputs 0 next cycle; fetch restarts at pc.
